// File: rtl/split_bus_pkg.sv
// Shared definitions for the split-transaction serial bus: initiator
// state encoding, bus direction constants and default bus widths.
package split_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUS_REQ    = 2'd1,
    ST_WAIT_RESP  = 2'd2,
    ST_SPLIT_WAIT = 2'd3
  } init_state_e;

  localparam logic BUS_RW_WRITE = 1'b1;
  localparam logic BUS_RW_READ  = 1'b0;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

endpackage

// File: rtl/split_initiator.sv
// Split-transaction bus initiator. Takes one local command, arbitrates for
// the bus, issues a single-cycle address/data strobe and completes on ack.
// A read deferred by split_ack releases the bus and completes later when
// the target returns data together with ack.
// Optional build macro SPLIT_INIT_TIMEOUT_EN adds a response-wait timeout
// of TIMEOUT_CYCLES cycles that completes the command with rsp_err=1.
module split_initiator
  import split_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_rw,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] init_addr_out,
  output logic                  init_addr_out_valid,
  output logic [DATA_WIDTH-1:0] init_data_out,
  output logic                  init_data_out_valid,
  output logic                  init_rw,
  input  logic [DATA_WIDTH-1:0] init_data_in,
  input  logic                  init_data_in_valid,
  input  logic                  init_ack,
  input  logic                  init_split_ack,
  input  logic                  init_ready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("split_initiator: TIMEOUT_CYCLES must be >= 1");
  end

  init_state_e           r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_cmd_addr, w_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wdata, w_cmd_wdata;
  logic                  r_cmd_rw, w_cmd_rw;
  logic                  r_bus_req, w_bus_req;
  logic [ADDR_WIDTH-1:0] r_addr_out, w_addr_out;
  logic                  r_addr_vld, w_addr_vld;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_out;
  logic                  r_data_vld, w_data_vld;
  logic                  r_rw_out, w_rw_out;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic                  r_rsp_err, w_rsp_err;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_done_data;
  logic                  w_issue;
  logic                  w_waiting;
  logic                  w_tmo_hit;

  assign w_issue   = (r_state == ST_BUS_REQ) && bus_grant && init_ready;
  assign w_waiting = (r_state == ST_WAIT_RESP) || (r_state == ST_SPLIT_WAIT);

`ifdef SPLIT_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  // The timeout fires in the cycle the counter is about to reach the limit,
  // so rsp_valid appears exactly TIMEOUT_CYCLES cycles after the strobe.
  assign w_tmo_hit = w_waiting && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for the response; restart on every issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_issue) begin
      r_tmo_cnt <= '0;
    end else if (w_waiting) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    w_state     = r_state;
    w_cmd_addr  = r_cmd_addr;
    w_cmd_wdata = r_cmd_wdata;
    w_cmd_rw    = r_cmd_rw;
    w_bus_req   = r_bus_req;
    w_addr_out  = r_addr_out;
    w_addr_vld  = 1'b0;
    w_data_out  = r_data_out;
    w_data_vld  = 1'b0;
    w_rw_out    = r_rw_out;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_done      = 1'b0;
    w_done_data = '0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_cmd_addr  = cmd_addr;
          w_cmd_wdata = cmd_wdata;
          w_cmd_rw    = cmd_rw;
          w_bus_req   = 1'b1;
          w_state     = ST_BUS_REQ;
        end
      end
      ST_BUS_REQ: begin
        if (w_issue) begin
          w_addr_vld = 1'b1;
          w_data_vld = (r_cmd_rw == BUS_RW_WRITE);
          w_addr_out = r_cmd_addr;
          w_data_out = r_cmd_wdata;
          w_rw_out   = r_cmd_rw;
          w_state    = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (r_cmd_rw == BUS_RW_WRITE) begin
          w_done = init_ack;
        end else if (r_cmd_rw == BUS_RW_READ) begin
          if (init_ack && init_data_in_valid) begin
            w_done      = 1'b1;
            w_done_data = init_data_in;
          end else if (init_split_ack && !init_ack) begin
            w_bus_req = 1'b0;
            w_state   = ST_SPLIT_WAIT;
          end
        end
      end
      ST_SPLIT_WAIT: begin
        if (init_ack && init_data_in_valid) begin
          w_done      = 1'b1;
          w_done_data = init_data_in;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    // Completion takes priority over a timeout in the same cycle.
    if (w_done) begin
      w_bus_req   = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_rdata = w_done_data;
      w_rsp_err   = 1'b0;
      w_state     = ST_IDLE;
    end else if (w_tmo_hit) begin
      w_bus_req   = 1'b0;
      w_rsp_valid = 1'b1;
      w_rsp_rdata = '0;
      w_rsp_err   = 1'b1;
      w_state     = ST_IDLE;
    end
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_rw    <= 1'b0;
      r_bus_req   <= 1'b0;
      r_addr_out  <= '0;
      r_addr_vld  <= 1'b0;
      r_data_out  <= '0;
      r_data_vld  <= 1'b0;
      r_rw_out    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      r_state     <= w_state;
      r_cmd_addr  <= w_cmd_addr;
      r_cmd_wdata <= w_cmd_wdata;
      r_cmd_rw    <= w_cmd_rw;
      r_bus_req   <= w_bus_req;
      r_addr_out  <= w_addr_out;
      r_addr_vld  <= w_addr_vld;
      r_data_out  <= w_data_out;
      r_data_vld  <= w_data_vld;
      r_rw_out    <= w_rw_out;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign cmd_ready           = (r_state == ST_IDLE);
  assign rsp_valid           = r_rsp_valid;
  assign rsp_rdata           = r_rsp_rdata;
  assign rsp_err             = r_rsp_err;
  assign bus_req             = r_bus_req;
  assign init_addr_out       = r_addr_out;
  assign init_addr_out_valid = r_addr_vld;
  assign init_data_out       = r_data_out;
  assign init_data_out_valid = r_data_vld;
  assign init_rw             = r_rw_out;

endmodule

// File: tb/tb_split_initiator.sv
// Testbench for split_initiator: directed bus-target stimulus, expected
// responses queued at command issue and checked by a separate monitor.
module tb_split_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_rw;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_grant;
  logic [15:0] init_addr_out;
  logic        init_addr_out_valid;
  logic [7:0]  init_data_out;
  logic        init_data_out_valid;
  logic        init_rw;
  logic [7:0]  init_data_in;
  logic        init_data_in_valid;
  logic        init_ack;
  logic        init_split_ack;
  logic        init_ready;

  split_initiator #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_addr            (cmd_addr),
    .cmd_wdata           (cmd_wdata),
    .cmd_rw              (cmd_rw),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .rsp_err             (rsp_err),
    .bus_req             (bus_req),
    .bus_grant           (bus_grant),
    .init_addr_out       (init_addr_out),
    .init_addr_out_valid (init_addr_out_valid),
    .init_data_out       (init_data_out),
    .init_data_out_valid (init_data_out_valid),
    .init_rw             (init_rw),
    .init_data_in        (init_data_in),
    .init_data_in_valid  (init_data_in_valid),
    .init_ack            (init_ack),
    .init_split_ack      (init_split_ack),
    .init_ready          (init_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus_grant          = 1'b0;
    init_ready         = 1'b0;
    init_ack           = 1'b0;
    init_split_ack     = 1'b0;
    init_data_in_valid = 1'b0;
    init_data_in       = 8'h00;
  endtask

  // Present a command for one cycle and queue the response it should get.
  task automatic issue_cmd(input logic rw, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rdata,
                           input logic exp_err);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
    check("bus_req_after_issue", bus_req, 1);
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  // Grant the bus for one cycle and check the single transaction strobe.
  task automatic grant_and_check(input logic rw, input logic [15:0] addr,
                                 input logic [7:0] wdata);
    bus_grant  = 1'b1;
    init_ready = 1'b1;
    tick();
    bus_grant  = 1'b0;
    init_ready = 1'b0;
    check("addr_strobe", init_addr_out_valid, 1);
    check("addr_value", init_addr_out, addr);
    check("data_strobe", init_data_out_valid, rw);
    check("rw_value", init_rw, rw);
    if (rw) check("wdata_value", init_data_out, wdata);
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b with nothing expected",
                   rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dropped;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = 16'h0000;
    cmd_wdata = 8'h00;
    clear_bus();
    tick();
    tick();
    check("reset_outputs",
          {rsp_valid, rsp_rdata, rsp_err, bus_req, init_addr_out, init_addr_out_valid,
           init_data_out, init_data_out_valid, init_rw}, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    tick();

    // Bus activity while idle is ignored.
    init_ack = 1'b1; init_split_ack = 1'b1; init_data_in_valid = 1'b1; init_data_in = 8'hFF;
    tick();
    clear_bus();
    tick();
    check("idle_ignore_bus_req", bus_req, 0);
    check("idle_ignore_ready", cmd_ready, 1);

    // Write 0x0012 <= 0xA5, grant two cycles after the request.
    issue_cmd(1'b1, 16'h0012, 8'hA5, 8'h00, 1'b0);
    tick();
    check("no_strobe_before_grant", init_addr_out_valid, 0);
    tick();
    grant_and_check(1'b1, 16'h0012, 8'hA5);
    tick();
    check("write_strobe_single", init_addr_out_valid, 0);
    check("write_data_strobe_single", init_data_out_valid, 0);
    init_ack = 1'b1;
    tick();
    clear_bus();
    check("write_rsp_valid", rsp_valid, 1);
    check("write_cmd_ready_with_rsp", cmd_ready, 1);
    check("write_bus_req_low", bus_req, 0);
    tick();

    // Read 0x0034 deferred by split_ack, data 0x5C returned later.
    issue_cmd(1'b0, 16'h0034, 8'h00, 8'h5C, 1'b0);
    grant_and_check(1'b0, 16'h0034, 8'h00);
    init_split_ack = 1'b1;
    tick();
    clear_bus();
    check("split_bus_req_drop", bus_req, 0);
    tick();
    init_ack = 1'b1;
    tick();
    clear_bus();
    init_data_in_valid = 1'b1; init_data_in = 8'hEE;
    tick();
    clear_bus();
    tick();
    check("split_lone_strobes_ignored", rsp_valid, 0);
    check("split_still_busy", cmd_ready, 0);
    tick();
    init_ack = 1'b1; init_data_in_valid = 1'b1; init_data_in = 8'h5C;
    tick();
    clear_bus();
    check("split_rsp_valid", rsp_valid, 1);
    tick();

    // Read with immediate ack+data 0x77; next command accepted in the rsp cycle.
    issue_cmd(1'b0, 16'h0040, 8'h00, 8'h77, 1'b0);
    grant_and_check(1'b0, 16'h0040, 8'h00);
    init_ack = 1'b1; init_data_in_valid = 1'b1; init_data_in = 8'h77;
    tick();
    clear_bus();
    check("direct_rsp_valid", rsp_valid, 1);
    check("direct_bus_req_low", bus_req, 0);

    // ack+split together: without data ignored, with data 0x11 completes.
    issue_cmd(1'b0, 16'h0041, 8'h00, 8'h11, 1'b0);
    grant_and_check(1'b0, 16'h0041, 8'h00);
    init_ack = 1'b1; init_split_ack = 1'b1;
    tick();
    check("ack_split_nodata_keeps_bus", bus_req, 1);
    check("ack_split_nodata_no_rsp", rsp_valid, 0);
    init_data_in_valid = 1'b1; init_data_in = 8'h11;
    tick();
    clear_bus();
    check("ack_split_rsp_valid", rsp_valid, 1);
    check("ack_split_bus_req_low", bus_req, 0);
    tick();

`ifdef SPLIT_INIT_TIMEOUT_EN
    // Split with no data return times out 8 cycles after the strobe edge.
    issue_cmd(1'b0, 16'h0050, 8'h00, 8'h00, 1'b1);
    grant_and_check(1'b0, 16'h0050, 8'h00);
    init_split_ack = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      clear_bus();
      check("timeout_not_yet", rsp_valid, 0);
    end
    tick();
    check("timeout_rsp_valid", rsp_valid, 1);
    check("timeout_rsp_err", rsp_err, 1);
    tick();
    issue_cmd(1'b1, 16'h00AA, 8'h3C, 8'h00, 1'b0);
    grant_and_check(1'b1, 16'h00AA, 8'h3C);
    init_ack = 1'b1;
    tick();
    clear_bus();
    check("after_timeout_rsp_valid", rsp_valid, 1);
    tick();
`endif

    // Reset while in split wait abandons the read with no response.
    issue_cmd(1'b0, 16'h0056, 8'h00, 8'h00, 1'b0);
    grant_and_check(1'b0, 16'h0056, 8'h00);
    init_split_ack = 1'b1;
    tick();
    clear_bus();
    check("pre_reset_split", bus_req, 0);
    #2;
    rst_n = 1'b0;
    #1;
    dropped = sb.pop_back();
    check("midreset_outputs",
          {rsp_valid, rsp_rdata, rsp_err, bus_req, init_addr_out, init_addr_out_valid,
           init_data_out, init_data_out_valid, init_rw}, 0);
    check("midreset_cmd_ready", cmd_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_no_rsp", rsp_valid, 0);

    // Write after reset completes normally.
    issue_cmd(1'b1, 16'h0077, 8'h5A, 8'h00, 1'b0);
    grant_and_check(1'b1, 16'h0077, 8'h5A);
    init_ack = 1'b1;
    tick();
    clear_bus();
    check("post_reset_write_rsp", rsp_valid, 1);
    tick();
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
